// File: rtl/rgb_led_pwm_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rgb_led_pwm_if                                                       |
// | Valid/ready colour write port feeding the RGB LED PWM block.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface rgb_led_pwm_if #(
  parameter int NUM_LEDS = 4,
  parameter int DUTY_W   = 8
);
  localparam int c_idx_w = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  logic                  wr_valid;
  logic                  wr_ready;
  logic [c_idx_w-1:0]    wr_idx;
  logic [3*DUTY_W-1:0]   wr_rgb;

  modport master (
    output wr_valid,
    output wr_idx,
    output wr_rgb,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_idx,
    input  wr_rgb,
    output wr_ready
  );
endinterface
`default_nettype wire

// File: rtl/rgb_led_pwm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rgb_led_pwm                                                          |
// | Per-LED 8-bit RGB PWM with double-buffered, frame-aligned updates.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rgb_led_pwm #(
  parameter int NUM_LEDS = 4,
  parameter int DUTY_W   = 8,
  parameter int PRESCALE = 250
) (
  input  wire logic                sclk,
  input  wire logic                resetn,
  input  wire logic                enable,
  rgb_led_pwm_if.slave             wr,
  output logic [NUM_LEDS-1:0]      led_r,
  output logic [NUM_LEDS-1:0]      led_g,
  output logic [NUM_LEDS-1:0]      led_b,
  output logic                     frame_start
);

  localparam int c_idx_w = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int c_slots = 2 ** c_idx_w;
  localparam int c_pre_w = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int c_rgb_w = 3 * DUTY_W;
  localparam logic [c_pre_w-1:0] c_pre_max   = c_pre_w'(PRESCALE - 1);
  localparam logic [DUTY_W-1:0]  c_phase_max = '1;

  logic [c_pre_w-1:0]  r_pre_cnt;
  logic [DUTY_W-1:0]   r_phase;
  logic                r_frame_start;
  logic                w_tick;
  logic                w_bnd;
  logic                w_accept;
  logic [NUM_LEDS-1:0] w_pflag;
  logic [c_slots-1:0]  w_flag_slot;

  assign w_tick = (r_pre_cnt == c_pre_max);
  assign w_bnd  = w_tick && (r_phase == c_phase_max);

  always_ff @(posedge sclk or negedge resetn) begin
    if (!resetn) begin
      r_pre_cnt     <= '0;
      r_phase       <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_pre_cnt     <= w_tick ? '0 : r_pre_cnt + 1'b1;
      r_frame_start <= w_bnd;
      if (w_tick) begin
        r_phase <= r_phase + 1'b1;
      end
    end
  end

  assign frame_start = r_frame_start;

  // Unused index slots read as "no pending value", so out-of-range writes
  // are always accepted and simply dropped.
  for (genvar s = 0; s < c_slots; s++) begin : g_slot
    if (s < NUM_LEDS) begin : g_used
      assign w_flag_slot[s] = w_pflag[s];
    end else begin : g_unused
      assign w_flag_slot[s] = 1'b0;
    end
  end

  assign wr.wr_ready = ~w_flag_slot[wr.wr_idx];
  assign w_accept    = wr.wr_valid && wr.wr_ready;

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_led
    localparam logic [c_idx_w-1:0] c_my_idx = c_idx_w'(i);

    logic               w_hit;
    logic               w_commit;
    logic               r_pflag;
    logic [c_rgb_w-1:0] r_pend;
    logic [c_rgb_w-1:0] r_active;
    logic               r_led_r;
    logic               r_led_g;
    logic               r_led_b;

    assign w_hit    = w_accept && (wr.wr_idx == c_my_idx);
    assign w_commit = w_bnd && r_pflag;

    // A hit implies the flag was clear, so it never collides with a commit.
    always_ff @(posedge sclk or negedge resetn) begin
      if (!resetn) begin
        r_pflag  <= 1'b0;
        r_pend   <= '0;
        r_active <= '0;
      end else begin
        if (w_hit) begin
          r_pend  <= wr.wr_rgb;
          r_pflag <= 1'b1;
        end else if (w_commit) begin
          r_pflag <= 1'b0;
        end
        if (w_commit) begin
          r_active <= r_pend;
        end
      end
    end

    always_ff @(posedge sclk or negedge resetn) begin
      if (!resetn) begin
        r_led_r <= 1'b0;
        r_led_g <= 1'b0;
        r_led_b <= 1'b0;
      end else begin
        r_led_r <= enable && (r_phase < r_active[c_rgb_w-1 -: DUTY_W]);
        r_led_g <= enable && (r_phase < r_active[2*DUTY_W-1 -: DUTY_W]);
        r_led_b <= enable && (r_phase < r_active[DUTY_W-1:0]);
      end
    end

    assign w_pflag[i] = r_pflag;
    assign led_r[i]   = r_led_r;
    assign led_g[i]   = r_led_g;
    assign led_b[i]   = r_led_b;
  end

endmodule
`default_nettype wire

// File: tb/tb_rgb_led_pwm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rgb_led_pwm                                                       |
// | Directed scoreboard bench for rgb_led_pwm at PRESCALE=2.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_rgb_led_pwm;

  localparam int c_frame = 512;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] led_r, led_g, led_b;
  logic       frame_start;
  logic [2:0] led3_r, led3_g, led3_b;
  logic       frame_start3;

  always #5 clk = ~clk;

  rgb_led_pwm_if #(.NUM_LEDS(4), .DUTY_W(8)) wif4 ();
  rgb_led_pwm_if #(.NUM_LEDS(3), .DUTY_W(8)) wif3 ();

  rgb_led_pwm #(.NUM_LEDS(4), .DUTY_W(8), .PRESCALE(2)) dut (
    .sclk(clk), .resetn(rst_n), .enable(enable), .wr(wif4),
    .led_r(led_r), .led_g(led_g), .led_b(led_b), .frame_start(frame_start)
  );

  rgb_led_pwm #(.NUM_LEDS(3), .DUTY_W(8), .PRESCALE(2)) dut3 (
    .sclk(clk), .resetn(rst_n), .enable(1'b1), .wr(wif3),
    .led_r(led3_r), .led_g(led3_g), .led_b(led3_b), .frame_start(frame_start3)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  typedef struct {
    int win;
    int led;
    int r;
    int g;
    int b;
    bit contig;
  } exp_t;

  exp_t sb[$];

  task automatic push_exp(input int win, input int led, input int r, input int g,
                          input int b, input bit contig);
    exp_t e;
    e.win = win; e.led = led; e.r = r; e.g = g; e.b = b; e.contig = contig;
    sb.push_back(e);
  endtask

  // Per-frame monitor: a window is the 512 samples after a frame_start,
  // ending with (and including) the next frame_start cycle.
  int fs_cnt;
  int win_len;
  int cnt [4][3];
  bit seen_low [4][3];
  bit broken [4][3];

  function automatic void clear_mon();
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 3; c++) begin
        cnt[i][c] = 0; seen_low[i][c] = 1'b0; broken[i][c] = 1'b0;
      end
    end
  endfunction

  initial begin
    logic v;
    exp_t e;
    bit   any_broken;
    fs_cnt = 0; win_len = 0; clear_mon();
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        fs_cnt = 0; win_len = 0; clear_mon();
      end else begin
        win_len++;
        for (int i = 0; i < 4; i++) begin
          for (int c = 0; c < 3; c++) begin
            v = (c == 0) ? led_r[i] : (c == 1) ? led_g[i] : led_b[i];
            if (v === 1'b1) begin
              cnt[i][c]++;
              if (seen_low[i][c]) broken[i][c] = 1'b1;
            end else begin
              seen_low[i][c] = 1'b1;
            end
          end
        end
        if (frame_start === 1'b1) begin
          if (fs_cnt > 0) begin
            check("frame_len", win_len, c_frame);
            while (sb.size() > 0 && sb[0].win <= fs_cnt) begin
              e = sb.pop_front();
              if (e.win < fs_cnt) begin
                check("stale_entry_win", e.win, fs_cnt);
              end else begin
                check($sformatf("w%0d_led%0d_r", e.win, e.led), cnt[e.led][0], e.r);
                check($sformatf("w%0d_led%0d_g", e.win, e.led), cnt[e.led][1], e.g);
                check($sformatf("w%0d_led%0d_b", e.win, e.led), cnt[e.led][2], e.b);
                if (e.contig) begin
                  any_broken = broken[e.led][0] | broken[e.led][1] | broken[e.led][2];
                  check($sformatf("w%0d_led%0d_contig", e.win, e.led), any_broken, 0);
                end
              end
            end
          end
          fs_cnt++;
          win_len = 0;
          clear_mon();
        end
      end
    end
  end

  task automatic push_std(input int win);
    push_exp(win, 0, 128, 256, 510, 1'b1);
  endtask

  task automatic wait_fs();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_start !== 1'b1 && n < c_frame + 8);
    check("frame_start_seen", frame_start, 1);
    #1;
  endtask

  task automatic do_write(input logic [1:0] idx, input logic [23:0] rgb,
                          output int stalls, output logic fs_prev);
    wif4.wr_valid = 1'b1; wif4.wr_idx = idx; wif4.wr_rgb = rgb;
    stalls = 0;
    #1;
    while (wif4.wr_ready !== 1'b1 && stalls < 2 * c_frame) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    check($sformatf("wr_ready_idx%0d", idx), wif4.wr_ready, 1);
    fs_prev = frame_start;
    @(posedge clk);
    #1;
    wif4.wr_valid = 1'b0;
  endtask

  task automatic count_to_first_fs(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_start !== 1'b1 && n < c_frame + 88);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   w, w3, e, stalls, n, n_hi;
    logic fs_prev;

    enable = 1'b1;
    wif4.wr_valid = 1'b0; wif4.wr_idx = '0; wif4.wr_rgb = '0;
    wif3.wr_valid = 1'b0; wif3.wr_idx = '0; wif3.wr_rgb = '0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_led_r", led_r, 0);
    check("rst_led_g", led_g, 0);
    check("rst_led_b", led_b, 0);
    check("rst_frame_start", frame_start, 0);
    for (int i = 0; i < 4; i++) begin
      wif4.wr_idx = 2'(i);
      #1;
      check($sformatf("rst_ready_idx%0d", i), wif4.wr_ready, 1);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Brightness on LED 0, first frame_start exactly one frame after release.
    do_write(2'd0, 24'h4080FF, stalls, fs_prev);
    check("wr0_stalls", stalls, 0);
    count_to_first_fs(n);
    check("first_fs_delay", n, c_frame);
    #1;
    w = fs_cnt;
    for (int k = 0; k < 2; k++) begin
      push_std(w + k);
      for (int l = 1; l < 4; l++) push_exp(w + k, l, 0, 0, 0, 1'b1);
    end
    wait_fs();
    wait_fs();

    // Backpressure on LED 1, independent LED 3 in the same frame.
    w = fs_cnt;
    push_std(w);     push_exp(w, 1, 0, 0, 0, 1'b1);       push_exp(w, 3, 0, 0, 0, 1'b1);
    push_std(w + 1); push_exp(w + 1, 1, 64, 0, 0, 1'b1);  push_exp(w + 1, 3, 0, 16, 0, 1'b1);
    push_std(w + 2); push_exp(w + 2, 1, 0, 0, 96, 1'b1);  push_exp(w + 2, 3, 0, 16, 0, 1'b1);
    do_write(2'd1, 24'h200000, stalls, fs_prev);
    check("wr1a_stalls", stalls, 0);
    do_write(2'd3, 24'h000800, stalls, fs_prev);
    check("wr3_stalls", stalls, 0);
    do_write(2'd1, 24'h000030, stalls, fs_prev);
    check("wr1b_stalled", (stalls > 0), 1);
    check("wr1b_after_bnd", fs_prev, 1);
    wait_fs();
    wait_fs();

    // Write landing exactly on the boundary edge.
    w3 = fs_cnt;
    repeat (c_frame - 1) @(negedge clk);
    wif4.wr_valid = 1'b1; wif4.wr_idx = 2'd2; wif4.wr_rgb = 24'h101010;
    #1;
    check("bnd_wr_ready", wif4.wr_ready, 1);
    @(posedge clk);
    #1;
    check("bnd_wr_in_bnd_cycle", frame_start, 1);
    wif4.wr_valid = 1'b0;
    wif4.wr_idx = 2'd2;
    #1;
    check("bnd_wr_flag_set", wif4.wr_ready, 0);
    push_exp(w3 + 1, 2, 0, 0, 0, 1'b1);
    push_exp(w3 + 2, 2, 32, 32, 32, 1'b1);
    wait_fs();
    wait_fs();
    wait_fs();

    // Duty zero, then gate enable mid-frame and re-enable.
    e = fs_cnt;
    do_write(2'd1, 24'h000000, stalls, fs_prev);
    check("wr1z_stalls", stalls, 0);
    push_exp(e + 1, 0, 28, 156, 410, 1'b0);
    push_exp(e + 1, 1, 0, 0, 0, 1'b1);
    push_exp(e + 1, 2, 20, 20, 20, 1'b0);
    push_exp(e + 1, 3, 0, 16, 0, 1'b0);
    push_std(e + 2);
    push_exp(e + 2, 1, 0, 0, 0, 1'b1);
    push_exp(e + 2, 2, 32, 32, 32, 1'b1);
    push_exp(e + 2, 3, 0, 16, 0, 1'b1);
    wait_fs();
    repeat (20) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("dis_led_r", led_r, 0);
    check("dis_led_g", led_g, 0);
    check("dis_led_b", led_b, 0);
    repeat (99) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    check("reen_led0_r", led_r[0], 1);
    check("reen_led0_b", led_b[0], 1);
    check("reen_led1_g", led_g[1], 0);
    wait_fs();
    wait_fs();

    // Asynchronous reset mid-frame with a pending write on LED 2.
    do_write(2'd2, 24'hFFFFFF, stalls, fs_prev);
    check("wr2p_stalls", stalls, 0);
    wif4.wr_idx = 2'd2;
    #1;
    check("pflag2_ready", wif4.wr_ready, 0);
    repeat (40) @(negedge clk);
    check("pre_rst_led0_r", led_r[0], 1);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_led_r", led_r, 0);
    check("mid_rst_led_g", led_g, 0);
    check("mid_rst_led_b", led_b, 0);
    check("mid_rst_frame_start", frame_start, 0);
    for (int i = 0; i < 4; i++) begin
      wif4.wr_idx = 2'(i);
      #1;
      check($sformatf("mid_rst_ready_idx%0d", i), wif4.wr_ready, 1);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    count_to_first_fs(n);
    check("post_rst_first_fs", n, c_frame);
    #1;
    w = fs_cnt;
    for (int k = 0; k < 2; k++) begin
      push_exp(w + k, 0, 0, 0, 0, 1'b1);
      push_exp(w + k, 2, 0, 0, 0, 1'b1);
    end
    wait_fs();
    wait_fs();

    // Out-of-range index on the three-LED instance.
    @(negedge clk);
    wif3.wr_valid = 1'b1; wif3.wr_idx = 2'd3; wif3.wr_rgb = 24'hFFFFFF;
    #1;
    check("oor_ready", wif3.wr_ready, 1);
    @(posedge clk);
    #1;
    wif3.wr_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wif3.wr_idx = 2'(i);
      #1;
      check($sformatf("oor_ready_after_idx%0d", i), wif3.wr_ready, 1);
    end
    n_hi = 0;
    repeat (2 * c_frame + 80) begin
      @(negedge clk);
      if ((led3_r | led3_g | led3_b) !== 3'b000) n_hi++;
    end
    check("oor_no_output", n_hi, 0);

    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rgb_led_pwm.md
# rgb_led_pwm

Drives the four RGB LEDs (led0..led3, r/g/b) with per-channel 8-bit PWM brightness. It is the output-side counterpart of the debounced switch/button input path. It sits beside `led_ctrl`, which loads colour values through a valid/ready write port. New colours are double-buffered and take effect only at a PWM frame boundary, so the outputs are glitch-free.

## Interface
Parameters:
- NUM_LEDS, 4, number of RGB LEDs driven.
- DUTY_W, 8, duty/phase width; a frame is 2^DUTY_W phase ticks.
- PRESCALE, 250, sclk cycles per phase tick (must be ≥ 1); 100 MHz gives a 1.5625 kHz frame.

Ports:
- sclk  in  1  system clock; everything is synchronous to its rising edge.
- resetn  in  1  reset; asynchronous assert, active-low.
- enable  in  1  1 = PWM outputs active; 0 = all colour outputs forced 0.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready on a rising edge.
- wr_idx  in  $clog2(NUM_LEDS)  target LED index.
- wr_rgb  in  3*DUTY_W  duty values, {red, green, blue}; red is the MSBs.
- led_r, led_g, led_b  out  NUM_LEDS each  registered PWM outputs; bit i drives LED i.
- frame_start  out  1  one-cycle pulse in the cycle the phase wraps to 0.

## Operation
- **Prescaler.** `pre_cnt` counts 0..PRESCALE-1 and wraps. `tick` = (pre_cnt == PRESCALE-1).
- **Phase counter.** `phase` is DUTY_W bits and increments on `tick`, wrapping from 2^DUTY_W-1 to 0.
- **Frame boundary.** `bnd` = tick && phase == 2^DUTY_W-1.
- **Registers per LED i:**
  - `active[i]` holds 3 duties and drives the outputs.
  - `pend[i]` holds 3 duties and is staged by the write port.
  - `pflag[i]` marks `pend[i]` as holding an uncommitted value.
- **Write port.**
  - wr_ready = ~pflag[wr_idx]. This is combinational from wr_idx and pflag; there is no dependency on wr_valid.
  - On accept: pend[wr_idx] <= wr_rgb and pflag[wr_idx] <= 1.
  - wr_idx ≥ NUM_LEDS: wr_ready = 1, and the write is accepted and discarded.
- **Commit.**
  - On `bnd`, for every i with pflag[i] = 1: active[i] <= pend[i] and pflag[i] <= 0.
  - LEDs without a flag keep their value.
  - A write accepted in the `bnd` cycle is not committed at that boundary. It sets its flag and commits at the following boundary.
  - If `bnd` and an accept hit the same idx, that idx necessarily has its flag clear. Its new pend/flag take precedence over the clear.
- **Output compare.** Each cycle, led_c[i] <= enable && (phase < active[i].c) for c in {r, g, b}.
  - Duty 0: never high.
  - Duty 255: high for 255 of 256 phase ticks.
  - Duty d: high for exactly d × PRESCALE cycles per frame.
- **Enable low.** Counters, write port and commit keep running. Only the outputs are gated.
- **frame_start.** frame_start <= bnd, so it is high in the first cycle with phase = 0.
- **Reset (resetn = 0), any time including mid-frame:**
  - All outputs go 0 immediately.
  - pre_cnt, phase, active, pend and pflag are cleared, and any pending writes are discarded.
  - wr_ready reads 1 because pflag = 0.

## Timing
- Write to visible output: at most one frame plus 2 cycles after the accept edge.
  - The commit happens on the `bnd` edge.
  - The output registers reflect the new duty one edge later, i.e. the cycle after frame_start rises.
- The output is a registered compare of the previous cycle's phase/active: one cycle of latency relative to phase.
- Minimum write throughput: one write per LED per frame. Writes to different LEDs within one frame do not stall each other.
- All outputs are registered except wr_ready.

## Test plan
All directed tests use PRESCALE=2, so one frame = 512 cycles.
1. **Reset.** Assert resetn=0 mid-frame with pflag[2] set. Required: all led_* = 0 and frame_start = 0 asynchronously, wr_ready = 1 for every idx. After release, first frame_start follows 512 cycles after reset release; LED 2 stays dark.
2. **Brightness.** enable=1; write idx 0 with rgb 0x40_80_FF. Required, for each frame after the next frame_start: led_r[0] high 128 cycles, led_g[0] high 256, led_b[0] high 510, in each case contiguous from phase 0. Other LEDs stay 0.
3. **Backpressure.** Write idx 1 twice in one frame. Required:
   - Second write sees wr_ready = 0 and stalls until the cycle after the boundary.
   - A same-frame write to idx 3 is accepted immediately.
   - The first value is displayed for one frame, then the second.
4. **Boundary write.** Write idx 2 = 0x10_10_10 exactly in the `bnd` cycle. Required: accepted, not shown in the frame that is starting, shown from the following frame.
5. **Enable/extremes.**
   - Duty 0x00_00_00 gives permanent low.
   - Deassert enable mid-frame: all outputs 0 on the next edge, frame_start still pulses every 512 cycles.
   - Re-enable: outputs resume at the correct phase without restarting the frame.
6. **Out-of-range index.** NUM_LEDS=3, wr_idx=3. Required: wr_ready = 1, write accepted, no output change.
